alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; clock port clk, reset port rst_n.
REQ-002 Parameter: ALU_LAT, default 1, number of clock edges from ALU inputs changing to ALU outputs valid (range 0..7).
REQ-003 Port: clk  input  1  block clock, all logic on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Ports: req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-006 Ports: req0_ready / req1_ready  output  1  requester N accepted this cycle (handshake = valid & ready).
REQ-007 Ports: req0_op / req1_op  input  2  requested ALU operation code.
REQ-008 Ports: req0_a, req0_b / req1_a, req1_b  input  4  requested operands.
REQ-009 Port: alu_op  output  2  operation driven to shared ALU (registered).
REQ-010 Ports: alu_a, alu_b  output  4  operands driven to shared ALU (registered).
REQ-011 Ports: alu_out  input  4; alu_c  input  1  ALU result and carry-out.
REQ-012 Port: rsp_valid  output  1  single-cycle response strobe.
REQ-013 Port: rsp_id  output  1  requester index owning the response.
REQ-014 Ports: rsp_out  output  4; rsp_c  output  1  captured ALU result and carry.
REQ-015 Port: busy  output  1  high while an operation is in EXEC.

Function
REQ-016 The FSM SHALL have two states: IDLE and EXEC.
REQ-017 In IDLE, exactly one reqN_ready SHALL be high, combinationally, iff at least one reqN_valid is high; both ready SHALL be low in EXEC.
REQ-018 Grant: if only one valid, grant it; if both valid, grant the requester not equal to last_grant (round-robin).
REQ-019 last_grant SHALL update to the granted index only on a handshake edge.
REQ-020 On handshake edge E0: alu_op/alu_a/alu_b SHALL load the granted request, the owner index SHALL be latched, a latency counter SHALL load ALU_LAT, and the state SHALL go to EXEC.
REQ-021 In EXEC the counter SHALL decrement each edge; at the edge where it equals 0 (edge E0+ALU_LAT+1) alu_out/alu_c SHALL be captured into rsp_out/rsp_c, rsp_id set to the owner, and the state SHALL return to IDLE.
REQ-022 rsp_valid SHALL be high for exactly the one cycle following the capture edge, otherwise low.
REQ-023 A new handshake SHALL be allowed in the cycle rsp_valid is high; maximum throughput is one operation per ALU_LAT+2 cycles.
REQ-024 alu_op/alu_a/alu_b SHALL hold their last values in IDLE and throughout EXEC.
REQ-025 rsp_out/rsp_c/rsp_id SHALL hold their last captured values when rsp_valid is low.
REQ-026 The op code SHALL be forwarded unmodified; all four encodings are legal.
REQ-027 reqN_valid deasserting while EXEC SHALL have no effect; the operation in flight completes.
REQ-028 busy SHALL equal (state == EXEC).

Reset
REQ-029 While rst_n is low: state=IDLE, counter=0, last_grant=1 (requester 0 wins first tie), alu_op/alu_a/alu_b=0, rsp_valid=0, rsp_id=0, rsp_out=0, rsp_c=0, busy=0.
REQ-030 Reset asserted mid-EXEC SHALL abort the operation immediately; no rsp_valid SHALL be produced for it.
REQ-031 After rst_n deasserts, the first handshake SHALL be possible on the first rising edge.

Verification
(Bench ALU model: registered, ALU_LAT=1, op=2'b00 gives out=(a+b)[3:0], c=carry.)
REQ-032 Single request: req0 op=00 a=4'h7 b=4'h3 at E0 -> alu_a=7, alu_b=3 after E0; rsp_valid after E2 with rsp_id=0, rsp_out=4'hA, rsp_c=0.
REQ-033 Carry: req1 op=00 a=4'hF b=4'h2 -> rsp_id=1, rsp_out=4'h1, rsp_c=1; busy high two cycles.
REQ-034 Contention from reset: both valid continuously -> grants alternate 0,1,0,1; each accepted every 3 cycles; rsp_id sequence 0,1,0,1.
REQ-035 Back-to-back: req0 held valid alone -> ready high in every rsp_valid cycle; accepts at edges E0, E3, E6.
REQ-036 Reset mid-EXEC: rst_n low one cycle after handshake -> busy=0, alu_*=0 immediately; no rsp_valid; next req0 handshake on first edge after release.
REQ-037 Withdraw during EXEC: req1 valid drops after handshake -> response still delivered with rsp_id=1.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - two requester ports, shared ALU port and response port of alu_arbiter
interface alu_arbiter_if;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] alu_op;
  logic [3:0] alu_a, alu_b;
  logic [3:0] alu_out;
  logic       alu_c;
  logic       rsp_valid;
  logic       rsp_id;
  logic [3:0] rsp_out;
  logic       rsp_c;
  logic       busy;

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
    input  alu_out, alu_c,
    output req0_ready, req1_ready, alu_op, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_out, rsp_c, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
    output alu_out, alu_c,
    input  req0_ready, req1_ready, alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_out, rsp_c, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one fixed-latency ALU between two requesters
module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt;
  logic       last_grant;
  logic       owner;
  logic       any_valid;
  logic       grant;
  logic       hs;

  // On a tie the requester that did not win last time gets the ALU.
  assign any_valid      = bus.req0_valid | bus.req1_valid;
  assign grant          = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
  assign hs             = (state == IDLE) & any_valid;
  assign bus.req0_ready = hs & ~grant;
  assign bus.req1_ready = hs & grant;
  assign bus.busy       = (state == EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = EXEC;
      EXEC:    if (cnt == 3'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= 3'd0;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      bus.alu_op    <= 2'd0;
      bus.alu_a     <= 4'd0;
      bus.alu_b     <= 4'd0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_out   <= 4'd0;
      bus.rsp_c     <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      if (hs) begin
        last_grant <= grant;
        owner      <= grant;
        cnt        <= 3'(ALU_LAT);
        bus.alu_op <= grant ? bus.req1_op : bus.req0_op;
        bus.alu_a  <= grant ? bus.req1_a  : bus.req0_a;
        bus.alu_b  <= grant ? bus.req1_b  : bus.req0_b;
      end else if (state == EXEC) begin
        if (cnt == 3'd0) begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_id    <= owner;
          bus.rsp_out   <= bus.alu_out;
          bus.rsp_c     <= bus.alu_c;
        end else begin
          cnt <= cnt - 3'd1;
        end
      end
    end
  end

endmodule
